// File: rtl/punc_controller_if.sv
// punc_controller_if: bundle between the PUnC control FSM and the PUnC datapath.
//   ir, N, Z, P       : datapath -> controller (instruction register, condition flags)
//   everything else   : controller -> datapath control inputs
// Modports: master = controller side, slave = datapath side.
interface punc_controller_if;
  logic [15:0] ir;
  logic        N, Z, P;
  logic        PC_ld_register, PC_ld_offset, PC_clr, PC_inc, IR_ld;
  logic [2:0]  readCtrAddr;
  logic [15:0] ctrAddr;
  logic        immSelect;
  logic [15:0] immValue;
  logic [2:0]  regFile_r_addr_0, regFile_r_addr_1, regFile_w_addr_0;
  logic        regFile_w_en;
  logic [2:0]  selectALU;
  logic        modCond;
  logic [2:0]  W_dataSelect_RF;
  logic [15:0] LOAD_offset;
  logic        memWriteEn;
  logic [1:0]  W_addrSelect_M;
  logic [15:0] WRITE_offset;
  logic        halted;

  modport master (
    input  ir, N, Z, P,
    output PC_ld_register, PC_ld_offset, PC_clr, PC_inc, IR_ld, readCtrAddr, ctrAddr,
           immSelect, immValue, regFile_r_addr_0, regFile_r_addr_1, regFile_w_addr_0,
           regFile_w_en, selectALU, modCond, W_dataSelect_RF, LOAD_offset, memWriteEn,
           W_addrSelect_M, WRITE_offset, halted
  );

  modport slave (
    output ir, N, Z, P,
    input  PC_ld_register, PC_ld_offset, PC_clr, PC_inc, IR_ld, readCtrAddr, ctrAddr,
           immSelect, immValue, regFile_r_addr_0, regFile_r_addr_1, regFile_w_addr_0,
           regFile_w_en, selectALU, modCond, W_dataSelect_RF, LOAD_offset, memWriteEn,
           W_addrSelect_M, WRITE_offset, halted
  );
endinterface

// File: rtl/punc_controller.sv
// punc_controller: control FSM for the PUnC LC3 processor.
// Fetch / decode / multi-cycle execute for ADD AND NOT BR JMP JSR(R) LD LDI LDR
// LEA ST STI STR and HALT; opcodes 1000 and 1101 execute as NOPs.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          punc_controller_if.master (ir/flags in, all datapath controls out)
//   instr_count  16-bit DECODE-cycle counter, only with PUNC_INSTR_COUNT_EN defined
// Optional feature macro: PUNC_INSTR_COUNT_EN.
module punc_controller #(
  parameter logic [2:0] R7_ADDR = 3'd7
) (
  input  logic clk,
  input  logic rst,
`ifdef PUNC_INSTR_COUNT_EN
  output logic [15:0] instr_count,
`endif
  punc_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EX1, S_EX2, S_EX3, S_SETCC, S_HALT
  } state_t;

  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST   = 4'h3,
                         OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
                         OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB, OP_JMP = 4'hC,
                         OP_LEA = 4'hE, OP_HALT = 4'hF;

  state_t state, state_nxt;

  logic [3:0]  op;
  logic [2:0]  dr, sr1;
  logic [15:0] imm5, off6, off9, off11;
  logic        br_taken;

  assign op       = bus.ir[15:12];
  assign dr       = bus.ir[11:9];
  assign sr1      = bus.ir[8:6];
  assign imm5     = {{11{bus.ir[4]}},  bus.ir[4:0]};
  assign off6     = {{10{bus.ir[5]}},  bus.ir[5:0]};
  assign off9     = {{7{bus.ir[8]}},   bus.ir[8:0]};
  assign off11    = {{5{bus.ir[10]}},  bus.ir[10:0]};
  assign br_taken = |(bus.ir[11:9] & {bus.N, bus.Z, bus.P});
  assign bus.ctrAddr = 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EX1;
      S_EX1: begin
        case (op)
          OP_HALT: state_nxt = S_HALT;
          OP_ADD, OP_AND, OP_NOT, OP_JMP, OP_JSR, OP_LD, OP_LDR, OP_LDI,
          OP_ST, OP_STR, OP_STI: state_nxt = S_EX2;
          default: state_nxt = S_FETCH;  // BR, LEA, undefined opcodes
        endcase
      end
      S_EX2: begin
        case (op)
          OP_LD, OP_LDR:  state_nxt = S_SETCC;
          OP_LDI, OP_STI: state_nxt = S_EX3;
          default:        state_nxt = S_FETCH;
        endcase
      end
      S_EX3:   state_nxt = (op == OP_LDI) ? S_SETCC : S_FETCH;
      S_SETCC: state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    bus.PC_ld_register   = 1'b0;
    bus.PC_ld_offset     = 1'b0;
    bus.PC_clr           = 1'b0;
    bus.PC_inc           = 1'b0;
    bus.IR_ld            = 1'b0;
    bus.readCtrAddr      = 3'd5;
    bus.immSelect        = 1'b0;
    bus.immValue         = 16'h0000;
    bus.regFile_r_addr_0 = 3'd0;
    bus.regFile_r_addr_1 = 3'd0;
    bus.regFile_w_addr_0 = 3'd0;
    bus.regFile_w_en     = 1'b0;
    bus.selectALU        = 3'd0;
    bus.modCond          = 1'b0;
    bus.W_dataSelect_RF  = 3'd0;
    bus.LOAD_offset      = 16'h0000;
    bus.memWriteEn       = 1'b0;
    bus.W_addrSelect_M   = 2'd3;
    bus.WRITE_offset     = 16'h0000;
    bus.halted           = 1'b0;
    case (state)
      S_RESET:  bus.PC_clr = 1'b1;
      S_FETCH:  bus.readCtrAddr = 3'd0;
      S_DECODE: begin
        bus.IR_ld  = 1'b1;
        bus.PC_inc = 1'b1;
      end
      S_EX1, S_EX2: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            // ALU selects held across both cycles; EX2 adds the writeback.
            bus.regFile_r_addr_0 = sr1;
            bus.regFile_r_addr_1 = bus.ir[2:0];
            bus.immSelect        = bus.ir[5];
            bus.immValue         = imm5;
            bus.selectALU        = (op == OP_ADD) ? 3'd0 : (op == OP_AND) ? 3'd1 : 3'd2;
            if (state == S_EX2) begin
              bus.regFile_w_addr_0 = dr;
              bus.regFile_w_en     = 1'b1;
              bus.modCond          = 1'b1;
            end
          end
          OP_BR: if (state == S_EX1 && br_taken) begin
            bus.PC_ld_offset = 1'b1;
            bus.WRITE_offset = off9;
          end
          OP_JMP: begin
            if (state == S_EX1) bus.regFile_r_addr_0 = sr1;
            else                bus.PC_ld_register   = 1'b1;
          end
          OP_JSR: begin
            // Link is written first, so JSRR R7 jumps to the fresh return address.
            if (state == S_EX1) begin
              bus.regFile_w_addr_0 = R7_ADDR;
              bus.W_dataSelect_RF  = 3'd2;
              bus.regFile_w_en     = 1'b1;
            end else if (bus.ir[11]) begin
              bus.PC_ld_offset = 1'b1;
              bus.WRITE_offset = off11;
            end else begin
              bus.regFile_r_addr_0 = sr1;
              bus.PC_ld_register   = 1'b1;
            end
          end
          OP_LEA: if (state == S_EX1) begin
            bus.regFile_w_addr_0 = dr;
            bus.W_dataSelect_RF  = 3'd3;
            bus.LOAD_offset      = off9;
            bus.regFile_w_en     = 1'b1;
          end
          OP_LD, OP_LDR: begin
            if (state == S_EX1) begin
              bus.readCtrAddr = (op == OP_LD) ? 3'd2 : 3'd4;
              bus.LOAD_offset = (op == OP_LD) ? off9 : off6;
              if (op == OP_LDR) bus.regFile_r_addr_0 = sr1;
            end else begin
              bus.W_dataSelect_RF  = 3'd1;
              bus.regFile_w_addr_0 = dr;
              bus.regFile_w_en     = 1'b1;
            end
          end
          OP_LDI, OP_STI: begin
            // Pointer fetch; the second read (LDI) or address latch (STI) follows.
            if (state == S_EX1) begin
              bus.readCtrAddr = 3'd2;
              bus.LOAD_offset = off9;
            end else if (op == OP_LDI) bus.readCtrAddr    = 3'd3;
            else                       bus.W_addrSelect_M = 2'd2;
          end
          OP_ST: begin
            bus.regFile_r_addr_0 = dr;
            bus.selectALU        = 3'd4;
            bus.W_addrSelect_M   = 2'd0;
            bus.WRITE_offset     = off9;
            bus.memWriteEn       = (state == S_EX2);
          end
          OP_STR: begin
            // EX1 latches the base+offset address; EX2 routes the source and writes.
            if (state == S_EX1) begin
              bus.regFile_r_addr_0 = sr1;
              bus.W_addrSelect_M   = 2'd1;
              bus.WRITE_offset     = off6;
            end else begin
              bus.regFile_r_addr_0 = dr;
              bus.selectALU        = 3'd4;
              bus.memWriteEn       = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX3: begin
        if (op == OP_LDI) begin
          bus.W_dataSelect_RF  = 3'd1;
          bus.regFile_w_addr_0 = dr;
          bus.regFile_w_en     = 1'b1;
        end else begin
          bus.regFile_r_addr_0 = dr;
          bus.selectALU        = 3'd4;
          bus.memWriteEn       = 1'b1;
        end
      end
      S_SETCC: begin
        bus.regFile_r_addr_0 = dr;
        bus.selectALU        = 3'd4;
        bus.modCond          = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

`ifdef PUNC_INSTR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                    instr_count <= 16'h0000;
    else if (state == S_DECODE) instr_count <= instr_count + 16'h0001;
  end
`endif
endmodule
